// File: rtl/pma_router_pkg.sv
// Types and reset constants for the PMA request router and its route FIFO.
package pma_router_pkg;
  import river_cfg_pkg::*;

  // One bit today: which port the outstanding request went to.
  typedef struct packed {
    logic cached;
  } route_fifo_entry;

  typedef struct packed {
    logic [CFG_CPU_ADDR_BITS-1:0] addr;
    logic                         write;
    logic [63:0]                  wdata;
    logic [7:0]                   wstrb;
    logic                         cached;
  } stage_type;

  localparam stage_type STAGE_RESET = '{addr: '0, write: 1'b0, wdata: '0,
                                        wstrb: '0, cached: 1'b0};
  localparam route_fifo_entry ROUTE_FIFO_ENTRY_RESET = '{cached: 1'b0};
endpackage

// File: rtl/river_cfg_pkg.sv
// Core-wide configuration constants shared by the memory-side blocks.
package river_cfg_pkg;
  localparam int CFG_CPU_ADDR_BITS = 32;
endpackage

// File: rtl/pma_route_fifo.sv
// DEPTH-entry route FIFO remembering which port each issued request used.
module pma_route_fifo
  import pma_router_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int LOG2_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  route_fifo_entry i_push_data,
  input  logic            i_pop,
  output logic            o_full,
  output logic            o_empty,
  output route_fifo_entry o_head
);

  localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH + 1)'(DEPTH);

  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic [LOG2_DEPTH:0]   cnt;
  route_fifo_entry       mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= ROUTE_FIFO_ENTRY_RESET;
    end else begin
      if (i_push) begin
        mem[wr_ptr] <= i_push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (i_pop) rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop leaves the count unchanged, even when full.
      if (i_push && !i_pop)      cnt <= cnt + 1'b1;
      else if (!i_push && i_pop) cnt <= cnt - 1'b1;
    end
  end

  assign o_full  = (cnt == FULL_CNT);
  assign o_empty = (cnt == '0);
  assign o_head  = mem[rd_ptr];

endmodule

// File: rtl/pma_req_router.sv
// Routes CPU data requests to the D$ or uncached port by PMA result and returns
// responses in request order. RIVER_PMA_ROUTER_STATS_EN adds per-port issue counters.
module pma_req_router
  import river_cfg_pkg::*;
  import pma_router_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [CFG_CPU_ADDR_BITS-1:0] i_req_addr,
  input  logic                         i_req_write,
  input  logic [63:0]                  i_req_wdata,
  input  logic [7:0]                   i_req_wstrb,
  output logic [CFG_CPU_ADDR_BITS-1:0] o_pma_addr,
  input  logic                         i_pma_cached,
  output logic [CFG_CPU_ADDR_BITS-1:0] o_fwd_addr,
  output logic                         o_fwd_write,
  output logic [63:0]                  o_fwd_wdata,
  output logic [7:0]                   o_fwd_wstrb,
  output logic                         o_c_req_valid,
  input  logic                         i_c_req_ready,
  output logic                         o_u_req_valid,
  input  logic                         i_u_req_ready,
  input  logic                         i_c_resp_valid,
  input  logic [63:0]                  i_c_resp_data,
  input  logic                         i_c_resp_err,
  output logic                         o_c_resp_ready,
  input  logic                         i_u_resp_valid,
  input  logic [63:0]                  i_u_resp_data,
  input  logic                         i_u_resp_err,
  output logic                         o_u_resp_ready,
  output logic                         o_resp_valid,
  output logic [63:0]                  o_resp_data,
  output logic                         o_resp_err,
  output logic                         o_resp_uncached,
  input  logic                         i_resp_ready,
  output logic                         o_unexp_resp
`ifdef RIVER_PMA_ROUTER_STATS_EN
  ,
  output logic [31:0]                  o_cnt_cached,
  output logic [31:0]                  o_cnt_uncached
`endif
);

  stage_type       stage;
  logic            stage_v;
  logic            fifo_full;
  logic            fifo_empty;
  route_fifo_entry head;
  logic            can_push;
  logic            issue;
  logic            pop;

  assign o_pma_addr = i_req_addr;

  assign can_push      = !fifo_full || pop;
  assign o_c_req_valid = stage_v && stage.cached && can_push;
  assign o_u_req_valid = stage_v && !stage.cached && can_push;
  assign issue         = (o_c_req_valid && i_c_req_ready) || (o_u_req_valid && i_u_req_ready);
  assign o_req_ready   = !stage_v || issue;

  assign o_fwd_addr  = stage.addr;
  assign o_fwd_write = stage.write;
  assign o_fwd_wdata = stage.wdata;
  assign o_fwd_wstrb = stage.wstrb;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_v <= 1'b0;
      stage   <= STAGE_RESET;
    end else if (i_req_valid && o_req_ready) begin
      stage_v <= 1'b1;
      stage   <= '{addr: i_req_addr, write: i_req_write, wdata: i_req_wdata,
                   wstrb: i_req_wstrb, cached: i_pma_cached};
    end else if (issue) begin
      stage_v <= 1'b0;
    end
  end

  pma_route_fifo #(
    .DEPTH      (DEPTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_route_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (issue),
    .i_push_data ('{cached: stage.cached}),
    .i_pop       (pop),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_head      (head)
  );

  // With nothing outstanding, stray responses are swallowed so neither port can stall.
  always_comb begin
    o_resp_valid    = 1'b0;
    o_resp_data     = '0;
    o_resp_err      = 1'b0;
    o_resp_uncached = 1'b0;
    o_c_resp_ready  = 1'b0;
    o_u_resp_ready  = 1'b0;
    if (fifo_empty) begin
      o_c_resp_ready = 1'b1;
      o_u_resp_ready = 1'b1;
    end else if (head.cached) begin
      o_resp_valid   = i_c_resp_valid;
      o_resp_data    = i_c_resp_data;
      o_resp_err     = i_c_resp_err;
      o_c_resp_ready = i_resp_ready;
    end else begin
      o_resp_valid    = i_u_resp_valid;
      o_resp_data     = i_u_resp_data;
      o_resp_err      = i_u_resp_err;
      o_resp_uncached = 1'b1;
      o_u_resp_ready  = i_resp_ready;
    end
  end

  assign pop = o_resp_valid && i_resp_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_unexp_resp <= 1'b0;
    end else if (fifo_empty && (i_c_resp_valid || i_u_resp_valid)) begin
      o_unexp_resp <= 1'b1;
    end
  end

`ifdef RIVER_PMA_ROUTER_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt_cached   <= '0;
      o_cnt_uncached <= '0;
    end else begin
      if (o_c_req_valid && i_c_req_ready && (o_cnt_cached != '1))
        o_cnt_cached <= o_cnt_cached + 32'd1;
      if (o_u_req_valid && i_u_req_ready && (o_cnt_uncached != '1))
        o_cnt_uncached <= o_cnt_uncached + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pma_req_router.sv
// Directed and randomized checks of pma_req_router against an in-order scoreboard.
module tb_pma_req_router;
  import river_cfg_pkg::*;

  localparam int AB    = CFG_CPU_ADDR_BITS;
  localparam int N_REQ = 200;

  typedef struct {
    logic [AB-1:0] addr;
    logic          write;
    logic [63:0]   wdata;
    logic [7:0]    wstrb;
  } req_t;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_req_valid, o_req_ready;
  logic [AB-1:0] i_req_addr, o_pma_addr, o_fwd_addr;
  logic          i_req_write, o_fwd_write;
  logic [63:0]   i_req_wdata, o_fwd_wdata;
  logic [7:0]    i_req_wstrb, o_fwd_wstrb;
  logic          i_pma_cached;
  logic          o_c_req_valid, i_c_req_ready, o_u_req_valid, i_u_req_ready;
  logic          i_c_resp_valid, i_c_resp_err, o_c_resp_ready;
  logic [63:0]   i_c_resp_data, i_u_resp_data, o_resp_data;
  logic          i_u_resp_valid, i_u_resp_err, o_u_resp_ready;
  logic          o_resp_valid, o_resp_err, o_resp_uncached, i_resp_ready;
  logic          o_unexp_resp;
`ifdef RIVER_PMA_ROUTER_STATS_EN
  logic [31:0]   o_cnt_cached, o_cnt_uncached;
`endif

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  // PMA model: everything at or above 0x8000_0000 is cacheable DRAM.
  function automatic logic is_cached(input logic [AB-1:0] a);
    return a >= 32'h8000_0000;
  endfunction
  function automatic logic [63:0] rdata(input logic [AB-1:0] a);
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction
  function automatic logic rerr(input logic [AB-1:0] a);
    return a[2];
  endfunction

  assign i_pma_cached = is_cached(o_pma_addr);

  pma_req_router dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_write(i_req_write),
    .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .o_pma_addr(o_pma_addr), .i_pma_cached(i_pma_cached),
    .o_fwd_addr(o_fwd_addr), .o_fwd_write(o_fwd_write),
    .o_fwd_wdata(o_fwd_wdata), .o_fwd_wstrb(o_fwd_wstrb),
    .o_c_req_valid(o_c_req_valid), .i_c_req_ready(i_c_req_ready),
    .o_u_req_valid(o_u_req_valid), .i_u_req_ready(i_u_req_ready),
    .i_c_resp_valid(i_c_resp_valid), .i_c_resp_data(i_c_resp_data),
    .i_c_resp_err(i_c_resp_err), .o_c_resp_ready(o_c_resp_ready),
    .i_u_resp_valid(i_u_resp_valid), .i_u_resp_data(i_u_resp_data),
    .i_u_resp_err(i_u_resp_err), .o_u_resp_ready(o_u_resp_ready),
    .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data),
    .o_resp_err(o_resp_err), .o_resp_uncached(o_resp_uncached),
    .i_resp_ready(i_resp_ready), .o_unexp_resp(o_unexp_resp)
`ifdef RIVER_PMA_ROUTER_STATS_EN
    , .o_cnt_cached(o_cnt_cached), .o_cnt_uncached(o_cnt_uncached)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_req_valid = 0; i_req_addr = '0; i_req_write = 0; i_req_wdata = '0; i_req_wstrb = '0;
    i_c_req_ready = 0; i_u_req_ready = 0; i_resp_ready = 0;
    i_c_resp_valid = 0; i_c_resp_data = '0; i_c_resp_err = 0;
    i_u_resp_valid = 0; i_u_resp_data = '0; i_u_resp_err = 0;
  endtask

  task automatic do_reset();
    i_rst = 1;
    tick();
    tick();
    i_rst = 0;
    #1;
  endtask

  initial begin
    req_t          acc_q[$];
    req_t          ord_q[$];
    logic [AB-1:0] cpend_q[$];
    logic [AB-1:0] upend_q[$];
    req_t          cur;
    logic          acc, ciss, uiss, crsp, ursp, pop;
    int            sent, done, cyc, n_c, n_u;
    logic [AB-1:0] base;

    idle();
    do_reset();

    // Reset state
    check("rst_req_ready", 64'(o_req_ready), 64'd1);
    check("rst_c_valid", 64'(o_c_req_valid), 64'd0);
    check("rst_u_valid", 64'(o_u_req_valid), 64'd0);
    check("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    check("rst_unexp", 64'(o_unexp_resp), 64'd0);

    // Single cached read
    i_c_req_ready = 1; i_u_req_ready = 1; i_resp_ready = 1;
    i_req_valid = 1; i_req_addr = 32'h8000_0000; i_req_write = 0;
    #1;
    check("c1_pma_addr", 64'(o_pma_addr), 64'h8000_0000);
    check("c1_req_ready", 64'(o_req_ready), 64'd1);
    check("c1_c_valid_pre", 64'(o_c_req_valid), 64'd0);
    tick();
    i_req_valid = 0;
    #1;
    check("c1_c_valid", 64'(o_c_req_valid), 64'd1);
    check("c1_u_valid", 64'(o_u_req_valid), 64'd0);
    check("c1_fwd_addr", 64'(o_fwd_addr), 64'h8000_0000);
    tick();
    check("c1_c_valid_post", 64'(o_c_req_valid), 64'd0);
    check("c1_resp_idle", 64'(o_resp_valid), 64'd0);
    i_c_resp_valid = 1; i_c_resp_data = 64'h1122_3344_5566_7788; i_c_resp_err = 0;
    #1;
    check("c1_resp_valid", 64'(o_resp_valid), 64'd1);
    check("c1_resp_data", o_resp_data, 64'h1122_3344_5566_7788);
    check("c1_resp_unc", 64'(o_resp_uncached), 64'd0);
    check("c1_c_resp_ready", 64'(o_c_resp_ready), 64'd1);
    check("c1_u_resp_ready", 64'(o_u_resp_ready), 64'd0);
    tick();
    i_c_resp_valid = 0;

    // Uncached CLINT read returning an error
    i_req_valid = 1; i_req_addr = 32'h0200_0000;
    tick();
    i_req_valid = 0;
    #1;
    check("u1_u_valid", 64'(o_u_req_valid), 64'd1);
    check("u1_c_valid", 64'(o_c_req_valid), 64'd0);
    tick();
    i_u_resp_valid = 1; i_u_resp_data = 64'hDEAD_BEEF_0000_0001; i_u_resp_err = 1;
    #1;
    check("u1_resp_valid", 64'(o_resp_valid), 64'd1);
    check("u1_resp_err", 64'(o_resp_err), 64'd1);
    check("u1_resp_unc", 64'(o_resp_uncached), 64'd1);
    check("u1_resp_data", o_resp_data, 64'hDEAD_BEEF_0000_0001);
    tick();
    i_u_resp_valid = 0; i_u_resp_err = 0;

    // Ordering: cached A then uncached B, B's response shows up first
    i_req_valid = 1; i_req_addr = 32'h8000_1000;
    tick();
    i_req_addr = 32'h1000_0000;
    #1;
    check("ord_a_issue", 64'(o_c_req_valid), 64'd1);
    check("ord_b_ready", 64'(o_req_ready), 64'd1);
    tick();
    i_req_valid = 0;
    #1;
    check("ord_b_issue", 64'(o_u_req_valid), 64'd1);
    tick();
    i_u_resp_valid = 1; i_u_resp_data = rdata(32'h1000_0000); i_u_resp_err = 0;
    #1;
    check("ord_b_held_rdy", 64'(o_u_resp_ready), 64'd0);
    check("ord_b_held_val", 64'(o_resp_valid), 64'd0);
    tick();
    check("ord_b_held2", 64'(o_resp_valid), 64'd0);
    i_c_resp_valid = 1; i_c_resp_data = rdata(32'h8000_1000);
    #1;
    check("ord_a_valid", 64'(o_resp_valid), 64'd1);
    check("ord_a_data", o_resp_data, rdata(32'h8000_1000));
    check("ord_a_unc", 64'(o_resp_uncached), 64'd0);
    check("ord_b_still_held", 64'(o_u_resp_ready), 64'd0);
    tick();
    i_c_resp_valid = 0;
    #1;
    check("ord_b_valid", 64'(o_resp_valid), 64'd1);
    check("ord_b_data", o_resp_data, rdata(32'h1000_0000));
    check("ord_b_unc", 64'(o_resp_uncached), 64'd1);
    check("ord_b_ready", 64'(o_u_resp_ready), 64'd1);
    tick();
    i_u_resp_valid = 0;
    #1;
    check("ord_drained", 64'(o_resp_valid), 64'd0);

    // Full FIFO: four issued, fifth parked in the stage, sixth blocked
    base = 32'h8000_2000;
    for (int k = 0; k < 5; k++) begin
      i_req_valid = 1; i_req_addr = base + 32'(k * 8);
      #1;
      check("full_acc", 64'(o_req_ready), 64'd1);
      tick();
    end
    i_req_addr = base + 32'd40;
    #1;
    check("full_blk_ready", 64'(o_req_ready), 64'd0);
    check("full_blk_cvalid", 64'(o_c_req_valid), 64'd0);
    check("full_stage_addr", 64'(o_fwd_addr), 64'(base + 32'd32));
    tick();
    check("full_blk_ready2", 64'(o_req_ready), 64'd0);
    i_c_resp_valid = 1; i_c_resp_data = rdata(base);
    #1;
    check("full_pop_data", o_resp_data, rdata(base));
    check("full_pop_issue", 64'(o_c_req_valid), 64'd1);
    check("full_pop_ready", 64'(o_req_ready), 64'd1);
    tick();
    i_c_resp_valid = 0; i_req_valid = 0;
    #1;
    check("full_cnt_held", 64'(o_c_req_valid), 64'd0);
    check("full_cnt_ready", 64'(o_req_ready), 64'd0);
    check("full_stage6", 64'(o_fwd_addr), 64'(base + 32'd40));

    // Reset with three outstanding, then a stale D$ response
    idle();
    do_reset();
    i_c_req_ready = 1; i_resp_ready = 1;
    for (int k = 0; k < 3; k++) begin
      i_req_valid = 1; i_req_addr = 32'h8000_3000 + 32'(k * 8);
      tick();
    end
    i_req_valid = 0;
    tick();
    i_rst = 1;
    tick();
    i_rst = 0;
    i_c_resp_valid = 1; i_c_resp_data = 64'h5;
    #1;
    check("rst_stale_ready", 64'(o_c_resp_ready), 64'd1);
    check("rst_stale_valid", 64'(o_resp_valid), 64'd0);
    check("rst_no_issue", 64'(o_c_req_valid), 64'd0);
    tick();
    i_c_resp_valid = 0;
    #1;
    check("rst_unexp_set", 64'(o_unexp_resp), 64'd1);
    tick();
    check("rst_unexp_sticky", 64'(o_unexp_resp), 64'd1);

    // Randomized traffic against the in-order scoreboard
    idle();
    do_reset();
    sent = 0; done = 0; cyc = 0; n_c = 0; n_u = 0;
    while (done < N_REQ && cyc < 20000) begin
      if (!i_req_valid && sent < N_REQ && $urandom_range(0, 3) != 0) begin
        i_req_valid = 1;
        i_req_addr  = $urandom;
        i_req_addr[31] = 1'($urandom_range(0, 1));
        i_req_write = 1'($urandom_range(0, 1));
        i_req_wdata = {$urandom, $urandom};
        i_req_wstrb = 8'($urandom);
      end
      i_c_req_ready = ($urandom_range(0, 3) != 0);
      i_u_req_ready = ($urandom_range(0, 3) != 0);
      i_resp_ready  = ($urandom_range(0, 3) != 0);
      if (!i_c_resp_valid && cpend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        i_c_resp_valid = 1; i_c_resp_data = rdata(cpend_q[0]); i_c_resp_err = rerr(cpend_q[0]);
      end
      if (!i_u_resp_valid && upend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        i_u_resp_valid = 1; i_u_resp_data = rdata(upend_q[0]); i_u_resp_err = rerr(upend_q[0]);
      end
      #1;
      acc  = i_req_valid && o_req_ready;
      ciss = o_c_req_valid && i_c_req_ready;
      uiss = o_u_req_valid && i_u_req_ready;
      crsp = i_c_resp_valid && o_c_resp_ready;
      ursp = i_u_resp_valid && o_u_resp_ready;
      pop  = o_resp_valid && i_resp_ready;
      if (pop) begin
        if (ord_q.size() == 0) begin
          check("rnd_spurious_resp", 64'(pop), 64'd0);
        end else begin
          check("rnd_resp_data", o_resp_data, rdata(ord_q[0].addr));
          check("rnd_resp_err", 64'(o_resp_err), 64'(rerr(ord_q[0].addr)));
          check("rnd_resp_unc", 64'(o_resp_uncached), 64'(!is_cached(ord_q[0].addr)));
          void'(ord_q.pop_front());
          done++;
        end
      end
      if (ciss || uiss) begin
        if (acc_q.size() == 0) begin
          check("rnd_spurious_issue", 64'(ciss || uiss), 64'd0);
        end else begin
          cur = acc_q.pop_front();
          check("rnd_iss_addr", 64'(o_fwd_addr), 64'(cur.addr));
          check("rnd_iss_port", 64'(ciss), 64'(is_cached(cur.addr)));
          check("rnd_iss_payload", {o_fwd_wdata[54:0], o_fwd_wstrb, o_fwd_write},
                {cur.wdata[54:0], cur.wstrb, cur.write});
          ord_q.push_back(cur);
          if (ciss) begin cpend_q.push_back(cur.addr); n_c++; end
          else begin upend_q.push_back(cur.addr); n_u++; end
        end
      end
      if (acc) begin
        cur.addr = i_req_addr; cur.write = i_req_write;
        cur.wdata = i_req_wdata; cur.wstrb = i_req_wstrb;
      end
      tick();
      if (acc) begin
        acc_q.push_back(cur);
        i_req_valid = 0;
        sent++;
      end
      if (crsp) begin i_c_resp_valid = 0; void'(cpend_q.pop_front()); end
      if (ursp) begin i_u_resp_valid = 0; void'(upend_q.pop_front()); end
      cyc++;
    end
    check("rnd_all_done", 64'(done), 64'(N_REQ));
    check("rnd_unexp_clean", 64'(o_unexp_resp), 64'd0);
`ifdef RIVER_PMA_ROUTER_STATS_EN
    check("stat_cached", 64'(o_cnt_cached), 64'(n_c));
    check("stat_uncached", 64'(o_cnt_uncached), 64'(n_u));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
